// File: rtl/capture_frame_sched_pkg.sv
// Shared definitions for the capture-side frame-buffer scheduler.
package capture_frame_sched_pkg;

   // Number of frame-buffer banks handled ping-pong style
   localparam int NBANK      = 2;
   localparam int BANK_IDX_W = 1;

   // Width of the frame and drop counters
   localparam int CW = 16;

   // Life cycle of one bank: FREE -> FILL -> FULL -> BUSY -> FREE
   typedef enum logic [1:0] {
      BANK_FREE = 2'd0,
      BANK_FILL = 2'd1,
      BANK_FULL = 2'd2,
      BANK_BUSY = 2'd3
   } bank_state_t;

endpackage

// File: rtl/capture_frame_sched_fs_vsync_edge.sv
// Two-flop vsync delay line; frame_start pulses on the falling edge of vsync,
// aligned with the cycle in which the capture block sees the same edge.
module fs_vsync_edge (
   input  logic clk,
   input  logic rstn,
   input  logic vsync,
   output logic frame_start
);

   logic vs_d1;
   logic vs_d2;

   // Delay raw vsync by one and two cycles
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         vs_d1 <= 1'b0;
         vs_d2 <= 1'b0;
      end else begin
         vs_d1 <= vsync;
         vs_d2 <= vs_d1;
      end
   end

   assign frame_start = !vs_d1 && vs_d2;

endmodule

// File: rtl/capture_frame_sched.sv
// Ping-pong frame-buffer scheduler: arms a bank per camera frame, routes the
// capture writes into it, hands finished frames to the consumer in order and
// shadows the crop/scale configuration onto frame boundaries.
module capture_frame_sched
   import capture_frame_sched_pkg::*;
#(
   parameter int AW = 12,
   parameter int DW = 8,
   parameter int PW = 10,
   parameter int PH = 10,
   parameter int CW = capture_frame_sched_pkg::CW
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          sched_en,
   input  logic [PW-1:0] cfg_x,
   input  logic [PH-1:0] cfg_y,
   input  logic [PW-1:0] cfg_w,
   input  logic [PH-1:0] cfg_h,
   input  logic [2:0]    cfg_scale,
   input  logic          cfg_update,
   output logic [PW-1:0] cap_x,
   output logic [PH-1:0] cap_y,
   output logic [PW-1:0] cap_w,
   output logic [PH-1:0] cap_h,
   output logic [2:0]    cap_scale,
   input  logic          cam_vsync_i,
   input  logic          cap_ready_i,
   input  logic [AW-1:0] cap_ab_i,
   input  logic          cap_cenb_i,
   input  logic [DW-1:0] cap_db_i,
   output logic [AW:0]   fb_ab_o,
   output logic          fb_cenb_o,
   output logic [DW-1:0] fb_db_o,
   output logic          frm_valid_o,
   output logic          frm_bank_o,
   input  logic          frm_ready_i,
   input  logic          frm_done_i,
   output logic [CW-1:0] frame_cnt_o,
   output logic [CW-1:0] drop_cnt_o
);

   logic frame_start;

   bank_state_t bank_reg  [NBANK];
   bank_state_t bank_next [NBANK];

   // Completed banks, oldest first
   logic [BANK_IDX_W-1:0] ord_reg  [2];
   logic [BANK_IDX_W-1:0] ord_next [2];
   logic [1:0]            ord_cnt_reg;
   logic [1:0]            ord_cnt_next;

   logic                  armed_reg;
   logic                  armed_next;
   logic [BANK_IDX_W-1:0] wr_bank_reg;
   logic [BANK_IDX_W-1:0] wr_bank_next;
   logic [CW-1:0]         frame_cnt_reg;
   logic [CW-1:0]         frame_cnt_next;
   logic [CW-1:0]         drop_cnt_reg;
   logic [CW-1:0]         drop_cnt_next;
   logic                  frm_valid_reg;
   logic                  frm_valid_next;
   logic                  frm_bank_reg;
   logic                  frm_bank_next;
   logic                  pend_reg;

   logic                  fill_hit;
   logic [BANK_IDX_W-1:0] fill_idx;
   logic                  free_hit;
   logic [BANK_IDX_W-1:0] free_idx;
   logic                  any_busy;

   fs_vsync_edge u_vsync_edge (
      .clk         (clk),
      .rstn        (rstn),
      .vsync       (cam_vsync_i),
      .frame_start (frame_start)
   );

   // Apply release, accept, completion and then arming, in that order
   always_comb begin
      bank_next      = bank_reg;
      ord_next       = ord_reg;
      ord_cnt_next   = ord_cnt_reg;
      armed_next     = armed_reg;
      wr_bank_next   = wr_bank_reg;
      frame_cnt_next = frame_cnt_reg;
      drop_cnt_next  = drop_cnt_reg;
      fill_hit       = 1'b0;
      fill_idx       = '0;
      free_hit       = 1'b0;
      free_idx       = '0;
      any_busy       = 1'b0;

      if (frm_done_i) begin
         for (int b = 0; b < NBANK; b++) begin
            if (bank_reg[b] == BANK_BUSY) bank_next[b] = BANK_FREE;
         end
      end

      // The offered frame is always the head of the order record
      if (frm_valid_reg && frm_ready_i) begin
         bank_next[frm_bank_reg] = BANK_BUSY;
         ord_next[0]             = ord_reg[1];
         ord_cnt_next            = ord_cnt_reg - 2'd1;
      end

      if (cap_ready_i && armed_reg) begin
         bank_next[wr_bank_reg]      = BANK_FULL;
         ord_next[ord_cnt_next[0]]   = wr_bank_reg;
         ord_cnt_next                = ord_cnt_next + 2'd1;
         armed_next                  = 1'b0;
         frame_cnt_next              = frame_cnt_reg + 1'b1;
      end

      // Scan downwards so the lowest index wins
      for (int b = NBANK - 1; b >= 0; b--) begin
         if (bank_next[b] == BANK_FILL) begin
            fill_hit = 1'b1;
            fill_idx = BANK_IDX_W'(b);
         end
         if (bank_next[b] == BANK_FREE) begin
            free_hit = 1'b1;
            free_idx = BANK_IDX_W'(b);
         end
      end

      if (frame_start) begin
         if (sched_en) begin
            if (fill_hit) begin
               // Previous frame never completed: reuse its bank
               armed_next   = 1'b1;
               wr_bank_next = fill_idx;
            end else if (free_hit) begin
               bank_next[free_idx] = BANK_FILL;
               armed_next          = 1'b1;
               wr_bank_next        = free_idx;
            end else begin
               armed_next = 1'b0;
               if (drop_cnt_reg != '1) drop_cnt_next = drop_cnt_reg + 1'b1;
            end
         end else begin
            armed_next = 1'b0;
            for (int b = 0; b < NBANK; b++) begin
               if (bank_next[b] == BANK_FILL) bank_next[b] = BANK_FREE;
            end
         end
      end

      for (int b = 0; b < NBANK; b++) begin
         if (bank_next[b] == BANK_BUSY) any_busy = 1'b1;
      end

      frm_valid_next = (ord_cnt_next != 2'd0) && !any_busy;
      frm_bank_next  = ord_next[0];
   end

   // Scheduler state registers
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int b = 0; b < NBANK; b++) bank_reg[b] <= BANK_FREE;
         ord_reg[0]    <= '0;
         ord_reg[1]    <= '0;
         ord_cnt_reg   <= 2'd0;
         armed_reg     <= 1'b0;
         wr_bank_reg   <= '0;
         frame_cnt_reg <= '0;
         drop_cnt_reg  <= '0;
         frm_valid_reg <= 1'b0;
         frm_bank_reg  <= 1'b0;
      end else begin
         bank_reg      <= bank_next;
         ord_reg       <= ord_next;
         ord_cnt_reg   <= ord_cnt_next;
         armed_reg     <= armed_next;
         wr_bank_reg   <= wr_bank_next;
         frame_cnt_reg <= frame_cnt_next;
         drop_cnt_reg  <= drop_cnt_next;
         frm_valid_reg <= frm_valid_next;
         frm_bank_reg  <= frm_bank_next;
      end
   end

   // Shadow configuration: load only on a frame start with an update pending
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_reg  <= 1'b0;
         cap_x     <= '0;
         cap_y     <= '0;
         cap_w     <= '0;
         cap_h     <= '0;
         cap_scale <= 3'd1;
      end else if (frame_start && (pend_reg || cfg_update)) begin
         pend_reg  <= 1'b0;
         cap_x     <= cfg_x;
         cap_y     <= cfg_y;
         cap_w     <= cfg_w;
         cap_h     <= cfg_h;
         cap_scale <= cfg_scale;
      end else if (cfg_update) begin
         pend_reg <= 1'b1;
      end
   end

   // Write path: steer capture writes into the armed bank, block otherwise
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         fb_ab_o   <= '0;
         fb_db_o   <= '0;
         fb_cenb_o <= 1'b1;
      end else begin
         fb_ab_o   <= {wr_bank_reg, cap_ab_i};
         fb_db_o   <= cap_db_i;
         fb_cenb_o <= cap_cenb_i | !armed_reg;
      end
   end

   assign frm_valid_o = frm_valid_reg;
   assign frm_bank_o  = frm_bank_reg;
   assign frame_cnt_o = frame_cnt_reg;
   assign drop_cnt_o  = drop_cnt_reg;

endmodule

// File: tb/tb_capture_frame_sched.sv
// Directed bench for capture_frame_sched with a queue-based reference model.
module tb_capture_frame_sched;

   localparam int AW = 8;
   localparam int DW = 8;
   localparam int PW = 10;
   localparam int PH = 10;
   localparam int CW = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rstn, sched_en, cfg_update;
   logic [PW-1:0] cfg_x, cfg_w, cap_x, cap_w;
   logic [PH-1:0] cfg_y, cfg_h, cap_y, cap_h;
   logic [2:0]    cfg_scale, cap_scale;
   logic          cam_vsync_i, cap_ready_i, cap_cenb_i;
   logic [AW-1:0] cap_ab_i;
   logic [DW-1:0] cap_db_i;
   logic [AW:0]   fb_ab_o;
   logic          fb_cenb_o;
   logic [DW-1:0] fb_db_o;
   logic          frm_valid_o, frm_bank_o, frm_ready_i, frm_done_i;
   logic [CW-1:0] frame_cnt_o, drop_cnt_o;

   capture_frame_sched #(.AW(AW), .DW(DW), .PW(PW), .PH(PH), .CW(CW)) dut (
      .clk(clk), .rstn(rstn), .sched_en(sched_en),
      .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .cfg_scale(cfg_scale), .cfg_update(cfg_update),
      .cap_x(cap_x), .cap_y(cap_y), .cap_w(cap_w), .cap_h(cap_h),
      .cap_scale(cap_scale),
      .cam_vsync_i(cam_vsync_i), .cap_ready_i(cap_ready_i),
      .cap_ab_i(cap_ab_i), .cap_cenb_i(cap_cenb_i), .cap_db_i(cap_db_i),
      .fb_ab_o(fb_ab_o), .fb_cenb_o(fb_cenb_o), .fb_db_o(fb_db_o),
      .frm_valid_o(frm_valid_o), .frm_bank_o(frm_bank_o),
      .frm_ready_i(frm_ready_i), .frm_done_i(frm_done_i),
      .frame_cnt_o(frame_cnt_o), .drop_cnt_o(drop_cnt_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Bank bookkeeping by role: which bank is filling, which one the consumer
   // holds, and the queue of completed banks; everything else is free.
   int            m_fill = -1;
   int            m_busy = -1;
   int            m_q[$];
   logic          m_last = 1'b0;
   bit            m_v1 = 0, m_v2 = 0, m_pend = 0;
   logic [PW-1:0] m_x = '0, m_w = '0;
   logic [PH-1:0] m_y = '0, m_h = '0;
   logic [2:0]    m_s = 3'd1;
   int            m_fcnt = 0, m_dcnt = 0;
   bit            e_valid = 0;
   int            e_bank = 0;
   bit            e_cenb = 1;
   logic [AW:0]   e_ab = '0;
   logic [DW-1:0] e_db = '0;
   int            wr_seen = 0;
   bit            m_fs;
   int            m_pick;

   function automatic bit bank_free(input int b);
      if (b == m_fill || b == m_busy) return 0;
      foreach (m_q[i]) if (m_q[i] == b) return 0;
      return 1;
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_fill = -1; m_busy = -1; m_q.delete(); m_last = 1'b0;
         m_v1 = 0; m_v2 = 0; m_pend = 0;
         m_x = '0; m_y = '0; m_w = '0; m_h = '0; m_s = 3'd1;
         m_fcnt = 0; m_dcnt = 0;
         e_valid = 0; e_bank = 0; e_cenb = 1;
      end else begin
         m_fs = !m_v1 && m_v2;
         m_v2 = m_v1;
         m_v1 = cam_vsync_i;
         e_cenb = cap_cenb_i || (m_fill < 0);
         e_ab   = {m_last, cap_ab_i};
         e_db   = cap_db_i;
         if (frm_done_i && m_busy >= 0) m_busy = -1;
         if (e_valid && frm_ready_i) m_busy = m_q.pop_front();
         if (cap_ready_i && m_fill >= 0) begin
            m_q.push_back(m_fill);
            m_fill = -1;
            m_fcnt = (m_fcnt + 1) % 65536;
         end
         m_pend = m_pend || cfg_update;
         if (m_fs) begin
            if (sched_en) begin
               if (m_fill < 0) begin
                  m_pick = -1;
                  for (int b = 1; b >= 0; b--) if (bank_free(b)) m_pick = b;
                  if (m_pick >= 0) begin
                     m_fill = m_pick;
                     m_last = m_pick[0];
                  end else if (m_dcnt < 65535) begin
                     m_dcnt++;
                  end
               end
            end else begin
               m_fill = -1;
            end
            if (m_pend) begin
               m_x = cfg_x; m_y = cfg_y; m_w = cfg_w; m_h = cfg_h; m_s = cfg_scale;
               m_pend = 0;
            end
         end
         e_valid = (m_q.size() > 0) && (m_busy < 0);
         e_bank  = (m_q.size() > 0) ? m_q[0] : 0;
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      chk("frm_valid", frm_valid_o, e_valid);
      if (e_valid) chk("frm_bank", frm_bank_o, e_bank);
      chk("frame_cnt", frame_cnt_o, m_fcnt);
      chk("drop_cnt", drop_cnt_o, m_dcnt);
      chk("fb_cenb", fb_cenb_o, e_cenb);
      if (!e_cenb) begin
         chk("fb_ab", fb_ab_o, e_ab);
         chk("fb_db", fb_db_o, e_db);
      end
      chk("cap_x", cap_x, m_x);
      chk("cap_y", cap_y, m_y);
      chk("cap_w", cap_w, m_w);
      chk("cap_h", cap_h, m_h);
      chk("cap_scale", cap_scale, m_s);
      if (!fb_cenb_o) wr_seen++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      idle(2);
      rstn = 1'b1;
      idle(1);
   endtask

   // Returns inside the frame-start cycle
   task automatic vsync_fall();
      cam_vsync_i = 1'b1;
      idle(3);
      cam_vsync_i = 1'b0;
      tick();
   endtask

   task automatic send_pixels(input int n);
      for (int i = 0; i < n; i++) begin
         cap_cenb_i = 1'b0;
         cap_ab_i   = AW'(i);
         cap_db_i   = DW'($urandom);
         tick();
      end
      cap_cenb_i = 1'b1;
   endtask

   task automatic frame(input int npix, input bit done_pulse);
      vsync_fall();
      tick();
      send_pixels(npix);
      if (done_pulse) begin
         cap_ready_i = 1'b1;
         tick();
         cap_ready_i = 1'b0;
      end
      idle(2);
   endtask

   task automatic set_cfg(input int x, input int y, input int w, input int h, input int s);
      cfg_x = PW'(x); cfg_y = PH'(y); cfg_w = PW'(w); cfg_h = PH'(h); cfg_scale = 3'(s);
      cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
   endtask

   int exp_order[3] = '{0, 1, 0};

   initial begin
      rstn = 1'b0; sched_en = 1'b1; cfg_update = 1'b0;
      cfg_x = '0; cfg_y = '0; cfg_w = '0; cfg_h = '0; cfg_scale = 3'd1;
      cam_vsync_i = 1'b0; cap_ready_i = 1'b0; cap_cenb_i = 1'b1;
      cap_ab_i = '0; cap_db_i = '0; frm_ready_i = 1'b0; frm_done_i = 1'b0;
      idle(2);
      chk("reset_cenb", fb_cenb_o, 1);
      chk("reset_scale", cap_scale, 1);
      chk("reset_valid", frm_valid_o, 0);
      rstn = 1'b1;
      idle(1);

      // 1: three frames with a prompt consumer
      set_cfg(2, 1, 8, 4, 1);
      fork
         for (int f = 0; f < 3; f++) frame(32, 1);
         begin
            for (int f = 0; f < 3; f++) begin
               int k;
               k = 0;
               while (!frm_valid_o && k < 100) begin tick(); k++; end
               chk("ack_wait", (k < 100), 1);
               chk("order_bank", frm_bank_o, exp_order[f]);
               $display("[TB] frame %0d handed off from bank %0d", f, frm_bank_o);
               frm_ready_i = 1'b1;
               tick();
               frm_ready_i = 1'b0;
               idle(20);
               frm_done_i = 1'b1;
               tick();
               frm_done_i = 1'b0;
            end
         end
      join
      idle(3);
      chk("s1_frame_cnt", frame_cnt_o, 3);
      chk("s1_drop_cnt", drop_cnt_o, 0);
      chk("s1_cap_w", cap_w, 8);

      // 2: consumer never accepts, four frames
      do_reset();
      frame(16, 1);
      frame(16, 1);
      wr_seen = 0;
      frame(16, 1);
      frame(16, 1);
      chk("s2_writes_blocked", wr_seen, 0);
      chk("s2_drop_cnt", drop_cnt_o, 2);
      chk("s2_frame_cnt", frame_cnt_o, 2);
      chk("s2_valid_bank", frm_bank_o, 0);
      $display("[TB] four frames sent, drop_cnt=%0d", drop_cnt_o);

      // 3: configuration change mid-frame
      do_reset();
      set_cfg(2, 1, 8, 4, 1);
      frame(8, 1);
      chk("s3_cap_w_loaded", cap_w, 8);
      vsync_fall();
      tick();
      send_pixels(4);
      cfg_w = PW'(16);
      cfg_update = 1'b1;
      tick();
      cfg_update = 1'b0;
      chk("s3_cap_w_hold", cap_w, 8);
      send_pixels(4);
      idle(4);
      chk("s3_cap_w_hold2", cap_w, 8);
      vsync_fall();
      chk("s3_cap_w_fs", cap_w, 8);
      tick();
      chk("s3_cap_w_new", cap_w, 16);
      $display("[TB] cfg update applied, cap_w=%0d", cap_w);
      idle(4);

      // 4: an incomplete frame followed by a complete one
      do_reset();
      frame(32, 0);
      frame(32, 1);
      chk("s4_frame_cnt", frame_cnt_o, 1);
      chk("s4_drop_cnt", drop_cnt_o, 0);
      chk("s4_valid", frm_valid_o, 1);
      chk("s4_bank", frm_bank_o, 0);
      $display("[TB] re-armed frame landed in bank %0d", frm_bank_o);

      // 5: release on the exact frame-start cycle
      do_reset();
      frame(8, 1);
      chk("s5_valid0", frm_valid_o, 1);
      frm_ready_i = 1'b1;
      tick();
      frm_ready_i = 1'b0;
      frame(8, 1);
      chk("s5_valid_blocked", frm_valid_o, 0);
      vsync_fall();
      frm_done_i = 1'b1;
      tick();
      frm_done_i = 1'b0;
      chk("s5_valid_re", frm_valid_o, 1);
      chk("s5_bank_re", frm_bank_o, 1);
      cap_cenb_i = 1'b0;
      cap_ab_i = AW'(5);
      tick();
      cap_cenb_i = 1'b1;
      chk("s5_write_en", fb_cenb_o, 0);
      chk("s5_write_bank", fb_ab_o[AW], 0);
      $display("[TB] done on frame start: bank0 re-armed, bank %0d offered", frm_bank_o);
      idle(3);

      // 6: reset in the middle of an active capture
      do_reset();
      frame(8, 1);
      vsync_fall();
      tick();
      send_pixels(3);
      cap_cenb_i = 1'b0;
      tick();
      chk("s6_writing", fb_cenb_o, 0);
      rstn = 1'b0;
      #1;
      chk("s6_rst_cenb", fb_cenb_o, 1);
      chk("s6_rst_fcnt", frame_cnt_o, 0);
      chk("s6_rst_dcnt", drop_cnt_o, 0);
      chk("s6_rst_valid", frm_valid_o, 0);
      idle(2);
      rstn = 1'b1;
      cap_cenb_i = 1'b1;
      idle(1);
      frame(8, 1);
      chk("s6_after_valid", frm_valid_o, 1);
      chk("s6_after_bank", frm_bank_o, 0);
      $display("[TB] after mid-frame reset next frame in bank %0d", frm_bank_o);

      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
